clkmon_multi: RTL
=================

Name: clkmon_multi

Overview:
- Multi-channel frequency monitor in the CLK domain, successor to the single-channel clock monitor.
- Each monitored clock is divided externally by a toggle divider (factor P_MON_DIV) into a slow toggle line MON_TOG[i].
- The block synchronises each line and counts both edges over a programmable gate window of CLK cycles.
- It reports per-channel counts, checks them against per-channel limits, and raises live and sticky alarms. Supports continuous and single-shot modes.

Parameters:
- P_CH, 4, number of monitored channels (1..16).
- P_CNT_W, 16, count/result/limit width per channel.
- P_GATE, 100000, gate window length in CLK cycles (≥4).
- P_GATE_W, 24, width of gate counter; must satisfy P_GATE ≤ 2^P_GATE_W.
- P_SYNC, 2, synchroniser depth (≥2).

Ports:
- CLK  in  1  system clock; all registers.
- RESET_N  in  1  asynchronous, active-low reset.
- MON_TOG  in  P_CH  async toggle lines, one per monitored clock; edge rate must be < CLK/2.
- CONT  in  1  1 = continuous measurement, 0 = single-shot.
- START  in  1  single-cycle pulse; starts one window when idle and CONT=0.
- LIMIT_LO  in  P_CH*P_CNT_W  per-channel low limit, channel i at [i*P_CNT_W +: P_CNT_W].
- LIMIT_HI  in  P_CH*P_CNT_W  per-channel high limit, same packing.
- ALARM_CLR  in  P_CH  per-channel clear for ALARM_STICKY, single-cycle.
- MON_FREQ  out  P_CH*P_CNT_W  last completed count per channel, same packing.
- MEAS_VALID  out  1  one-cycle pulse when MON_FREQ/ALARM update.
- ALARM  out  P_CH  live out-of-range flag from last window.
- ALARM_STICKY  out  P_CH  latched alarm.
- BUSY  out  1  high in ARM or MEASURE.

Behaviour:
- Reset values:
  - MON_FREQ: all ones (meaning "no measurement").
  - MEAS_VALID, ALARM, ALARM_STICKY, BUSY: 0.
  - State: IDLE. Synchronisers and edge history: 0.
- Synchroniser:
  - P_SYNC flops per channel, plus one history flop.
  - An edge is sync_out ^ history. Each edge counts as 1; both polarities are counted.
- States:
  - IDLE -> ARM when CONT=1, or when START=1.
  - ARM lasts exactly 2 cycles. It loads history from sync_out, clears the counters, and loads the gate counter with P_GATE-1. Then -> MEASURE.
  - MEASURE: the gate counter decrements each cycle. Per channel, edge -> count+1, saturating at all ones with no wrap.
- End of window (gate counter == 0 in MEASURE):
  - Snapshot the channel count, including this cycle's edge, saturated.
  - Next cycle: MON_FREQ takes the snapshot and MEAS_VALID=1 for one cycle. Result latency is 1 cycle after the last gate cycle.
  - Same terminal cycle: if CONT=1, the counters restart at 0 and the gate counter reloads P_GATE-1, staying in MEASURE. Windows are back-to-back with no edge lost or double-counted.
  - If CONT=0 -> IDLE.
- Alarms (registered with MON_FREQ):
  - ALARM[i] = (snap < LIMIT_LO[i]) | (snap > LIMIT_HI[i]), unsigned compare.
  - Limits are sampled on the terminal cycle; changes mid-window affect only that compare.
  - If LO > HI, every result alarms.
- ALARM_STICKY[i]:
  - Set on any update with ALARM[i]=1.
  - Cleared by ALARM_CLR[i]. If set and clear coincide, set wins.
- Mode and start rules:
  - START while BUSY: ignored.
  - START with CONT=1: ignored (already running).
  - CONT falling mid-window: the current window completes and reports, then IDLE.
  - CONT rising while IDLE: enter ARM next cycle.
- Dead clock: count 0 -> alarm if LIMIT_LO>0.
- RESET_N low at any time: immediate return to reset values. Any partial window is discarded.
- BUSY = state != IDLE.

Decomposition:
- Package clkmon_pkg holds:
  - the state encoding (IDLE, ARM, MEASURE);
  - localparam ARM_CYCLES=2;
  - default widths, and the all-ones result constant function of P_CNT_W.
- Sub-module clkmon_ch, instantiated P_CH times via generate, contains:
  - synchroniser, history flop, edge detect;
  - saturating counter, snapshot, limit compare.
- The control FSM and gate counter stay in clkmon_multi.

Test Plan (P_GATE=1000, P_CH=4, P_CNT_W=16):
- Reset, then CONT=1, MON_TOG[0] toggling every 5 CLK -> first MEAS_VALID at about 1003 cycles. MON_FREQ ch0 = 200±1; ch1..3 = 0; after reset before the first window, all four = 16'hFFFF.
- LIMIT_LO[0]=190, LIMIT_HI[0]=210, ch0 rate changed to every 4 CLK -> ch0 count 250, ALARM[0]=1, ALARM_STICKY[0]=1. Rate restored -> ALARM[0]=0, sticky stays 1 until ALARM_CLR[0].
- P_CNT_W=8, toggle every 2 CLK (500 edges) -> MON_FREQ = 8'hFF, no wrap.
- CONT=0, START pulse -> exactly one MEAS_VALID, BUSY high about 1002 cycles then low. Second START while BUSY -> ignored, only one result.
- Continuous, toggles phase-aligned to the terminal gate cycle -> sum over 10 windows equals total edges driven (no loss or duplication).
- RESET_N asserted mid-window -> all outputs return to reset values immediately. ALARM_CLR coincident with a new alarm -> sticky stays 1.

Source files
------------

// File: rtl/clkmon_pkg.sv
// Shared types and constants for the multi-channel clock frequency monitor.
package clkmon_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StMeasure
   } state_e;

   localparam int unsigned ARM_CYCLES = 2;

   localparam int unsigned DEF_CH     = 4;
   localparam int unsigned DEF_CNT_W  = 16;
   localparam int unsigned DEF_GATE   = 100000;
   localparam int unsigned DEF_GATE_W = 24;
   localparam int unsigned DEF_SYNC   = 2;

   // "No measurement" marker: all ones in the low w bits (w <= 32).
   function automatic logic [31:0] all_ones(input int unsigned w);
      return 32'hFFFF_FFFF >> (32 - w);
   endfunction

endpackage

// File: rtl/clkmon_ch.sv
// One monitor channel: toggle-line synchroniser, edge detect, saturating edge counter,
// end-of-window snapshot, limit compare and sticky alarm.
module clkmon_ch
   import clkmon_pkg::*;
#(
   parameter int unsigned P_CNT_W = DEF_CNT_W,
   parameter int unsigned P_SYNC  = DEF_SYNC
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               tog,
   input  logic               arm,
   input  logic               meas,
   input  logic               term,
   input  logic [P_CNT_W-1:0] limit_lo,
   input  logic [P_CNT_W-1:0] limit_hi,
   input  logic               alarm_clr,
   output logic [P_CNT_W-1:0] freq,
   output logic               alarm,
   output logic               alarm_sticky
);

   localparam logic [P_CNT_W-1:0] CNT_MAX = P_CNT_W'(all_ones(P_CNT_W));

   logic [P_SYNC-1:0]  sync_q;
   logic               hist_q;
   logic               edge_det;
   logic [P_CNT_W-1:0] cnt_q, cnt_d;
   logic [P_CNT_W-1:0] snap;
   logic [P_CNT_W-1:0] freq_q;
   logic               alarm_q, alarm_d;
   logic               sticky_q, sticky_d;

   assign edge_det = sync_q[P_SYNC-1] ^ hist_q;

   // Count including this cycle's edge, so the terminal cycle's edge lands in the old window.
   assign snap = (edge_det && (cnt_q != CNT_MAX)) ? cnt_q + P_CNT_W'(1) : cnt_q;

   always_comb begin
      cnt_d    = cnt_q;
      alarm_d  = (snap < limit_lo) || (snap > limit_hi);
      sticky_d = sticky_q & ~alarm_clr;
      if (arm || term) begin
         cnt_d = '0;
      end else if (meas) begin
         cnt_d = snap;
      end
      if (term && alarm_d) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q   <= '0;
         hist_q   <= 1'b0;
         cnt_q    <= '0;
         freq_q   <= CNT_MAX;
         alarm_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[P_SYNC-2:0], tog};
         hist_q   <= sync_q[P_SYNC-1];
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         if (term) begin
            freq_q  <= snap;
            alarm_q <= alarm_d;
         end
      end
   end

   assign freq         = freq_q;
   assign alarm        = alarm_q;
   assign alarm_sticky = sticky_q;

endmodule

// File: rtl/clkmon_multi.sv
// Multi-channel frequency monitor: control FSM and gate counter shared by P_CH channels
// that count both edges of externally divided toggle lines over a fixed CLK window.
module clkmon_multi
   import clkmon_pkg::*;
#(
   parameter int unsigned P_CH     = DEF_CH,
   parameter int unsigned P_CNT_W  = DEF_CNT_W,
   parameter int unsigned P_GATE   = DEF_GATE,
   parameter int unsigned P_GATE_W = DEF_GATE_W,
   parameter int unsigned P_SYNC   = DEF_SYNC
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic [P_CH-1:0]         MON_TOG,
   input  logic                    CONT,
   input  logic                    START,
   input  logic [P_CH*P_CNT_W-1:0] LIMIT_LO,
   input  logic [P_CH*P_CNT_W-1:0] LIMIT_HI,
   input  logic [P_CH-1:0]         ALARM_CLR,
   output logic [P_CH*P_CNT_W-1:0] MON_FREQ,
   output logic                    MEAS_VALID,
   output logic [P_CH-1:0]         ALARM,
   output logic [P_CH-1:0]         ALARM_STICKY,
   output logic                    BUSY
);

   localparam logic [P_GATE_W-1:0] GATE_LOAD = P_GATE_W'(P_GATE - 1);
   localparam logic [1:0]          ARM_LAST  = 2'(ARM_CYCLES - 1);

   state_e              state_q, state_d;
   logic [1:0]          arm_q, arm_d;
   logic [P_GATE_W-1:0] gate_q, gate_d;
   logic                valid_q;
   logic                term;
   logic                arm;
   logic                meas;

   assign arm  = (state_q == StArm);
   assign meas = (state_q == StMeasure);
   assign term = meas && (gate_q == '0);

   always_comb begin
      state_d = state_q;
      arm_d   = arm_q;
      gate_d  = gate_q;
      case (state_q)
         StIdle: begin
            if (CONT || START) begin
               state_d = StArm;
               arm_d   = '0;
            end
         end
         StArm: begin
            gate_d = GATE_LOAD;
            if (arm_q == ARM_LAST) begin
               state_d = StMeasure;
            end else begin
               arm_d = arm_q + 2'd1;
            end
         end
         StMeasure: begin
            if (gate_q == '0) begin
               // Continuous mode reloads in the terminal cycle so windows abut exactly.
               if (CONT) begin
                  gate_d = GATE_LOAD;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               gate_d = gate_q - P_GATE_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StIdle;
         arm_q   <= '0;
         gate_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         arm_q   <= arm_d;
         gate_q  <= gate_d;
         valid_q <= term;
      end
   end

   assign MEAS_VALID = valid_q;
   assign BUSY       = (state_q != StIdle);

   for (genvar i = 0; i < P_CH; i++) begin : g_ch
      clkmon_ch #(
         .P_CNT_W (P_CNT_W),
         .P_SYNC  (P_SYNC)
      ) u_ch (
         .CLK          (CLK),
         .RESET_N      (RESET_N),
         .tog          (MON_TOG[i]),
         .arm          (arm),
         .meas         (meas),
         .term         (term),
         .limit_lo     (LIMIT_LO[i*P_CNT_W +: P_CNT_W]),
         .limit_hi     (LIMIT_HI[i*P_CNT_W +: P_CNT_W]),
         .alarm_clr    (ALARM_CLR[i]),
         .freq         (MON_FREQ[i*P_CNT_W +: P_CNT_W]),
         .alarm        (ALARM[i]),
         .alarm_sticky (ALARM_STICKY[i])
      );
   end

endmodule
